// File: rtl/i_mem.sv
// Instruction ROM (256 x 8) with a registered read and a two-digit 7-segment hex view of the fetched word.
// Latency: instruction is valid 1 clk after Read_Address is sampled; segDisplay follows combinationally.
// Backpressure: none, a new fetch is accepted on every rising edge.
module i_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] Read_Address,
    output logic [DATA_W-1:0] instruction,
    output logic [13:0]       segDisplay
);

    function automatic logic [DATA_W-1:0] rom_lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] word;
        case (addr)
            8'h00:   word = 8'h47;
            8'h01:   word = 8'h58;
            8'h02:   word = 8'h1D;
            8'h03:   word = 8'h06;
            8'h04:   word = 8'h92;
            8'h05:   word = 8'hC1;
            8'h06:   word = 8'h7F;
            8'h07:   word = 8'h20;
            8'h08:   word = 8'h35;
            8'h09:   word = 8'h8A;
            8'h0A:   word = 8'hE3;
            8'h0B:   word = 8'h11;
            8'h0C:   word = 8'h6C;
            8'h0D:   word = 8'hB4;
            8'h0E:   word = 8'h09;
            8'h0F:   word = 8'hFF;
            default: word = 8'h00;
        endcase
        return word;
    endfunction

    // Segment order {a,b,c,d,e,f,g}, active high, a in the MSB.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk) begin
        if (!RST) begin
            instruction <= '0;
        end else begin
            instruction <= rom_lookup(Read_Address);
        end
    end

    always_comb begin
        segDisplay = {hex_to_seg(instruction[7:4]), hex_to_seg(instruction[3:0])};
    end

endmodule

// File: tb/tb_i_mem.sv
// Directed and randomized fetches of i_mem compared against a table-driven ROM/segment model.
module tb_i_mem;

    logic        clk;
    logic        RST;
    logic [7:0]  Read_Address;
    logic [7:0]  instruction;
    logic [13:0] segDisplay;

    int total;
    int bad;

    logic [7:0] rom_model [256];
    logic [6:0] seg_model [16];
    logic [7:0] exp_instr;

    i_mem #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .RST          (RST),
        .Read_Address (Read_Address),
        .instruction  (instruction),
        .segDisplay   (segDisplay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] seg_of(input logic [7:0] v);
        return {seg_model[v[7:4]], seg_model[v[3:0]]};
    endfunction

    task automatic check_instr(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s instruction observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_seg(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s segDisplay observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, update the model, and compare shortly after the edge.
    task automatic step(input string tag, input logic rst, input logic [7:0] addr);
        RST = rst;
        Read_Address = addr;
        @(posedge clk);
        exp_instr = rst ? rom_model[addr] : 8'h00;
        #1;
        check_instr(tag, instruction, exp_instr);
        check_seg(tag, segDisplay, seg_of(exp_instr));
    endtask

    initial begin
        logic [7:0] init_words [16];
        logic [6:0] init_segs [16];
        logic [7:0] a;
        logic       r;
        total = 0;
        bad = 0;
        exp_instr = 8'h00;

        init_words = '{8'h47, 8'h58, 8'h1D, 8'h06, 8'h92, 8'hC1, 8'h7F, 8'h20,
                       8'h35, 8'h8A, 8'hE3, 8'h11, 8'h6C, 8'hB4, 8'h09, 8'hFF};
        init_segs  = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                       7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        for (int i = 0; i < 256; i++) rom_model[i] = (i < 16) ? init_words[i] : 8'h00;
        for (int i = 0; i < 16; i++) seg_model[i] = init_segs[i];

        RST = 1'b0;
        Read_Address = 8'h05;
        @(negedge clk);

        // Reset held for two edges with a live address.
        step("reset_edge1", 1'b0, 8'h05);
        check_seg("reset_seg_const", segDisplay, 14'h3F7E);
        step("reset_edge2", 1'b0, 8'h05);

        // Literal values from the worked examples.
        step("addr01", 1'b1, 8'h01);
        check_seg("addr01_const", segDisplay, 14'h2DFF);
        step("addr0F", 1'b1, 8'h0F);
        check_instr("addr0F_const", instruction, 8'hFF);
        check_seg("addr0F_seg_const", segDisplay, 14'h23C7);
        step("addr05", 1'b1, 8'h05);
        check_instr("addr05_const", instruction, 8'hC1);
        check_seg("addr05_seg_const", segDisplay, 14'h2730);
        step("addr80", 1'b1, 8'h80);
        step("addrFF", 1'b1, 8'hFF);
        check_seg("addrFF_seg_const", segDisplay, 14'h3F7E);

        // Output must hold while the address moves between edges.
        step("hold_setup", 1'b1, 8'h0A);
        Read_Address = 8'h01;
        #2;
        check_instr("hold_mid1", instruction, 8'hE3);
        Read_Address = 8'h0F;
        #1;
        check_instr("hold_mid2", instruction, 8'hE3);
        check_seg("hold_mid2", segDisplay, seg_of(8'hE3));

        // Sweep with a reset pulse injected mid-way.
        for (int i = 0; i < 16; i++) begin
            if (i == 7) step("sweep_rst", 1'b0, 8'(i));
            step("sweep", 1'b1, 8'(i));
        end

        // Randomized fetches, biased toward the populated region, with sporadic resets.
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            step("random", r, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
